// File: rtl/qam4_carrier_mod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : qam4_carrier_mod                                                  |
// | Brief   : 4-QAM carrier modulator; phase counter + quarter-wave sine LUT,   |
// |           3-stage registered pipeline, symbol-timing master for the S2P.    |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module qam4_carrier_mod #(
   parameter int PHASE_W      = 6,
   parameter int AMP_W        = 8,
   parameter int CARR_PER_SYM = 1,
   parameter int DC_LEAD      = 4
) (
   input  logic                    clock,
   input  logic                    reset,
   input  logic [1:0]              elojel_sin_cos,
   output logic                    data_change,
   output logic signed [AMP_W-1:0] sin_out,
   output logic signed [AMP_W-1:0] cos_out,
   output logic signed [AMP_W:0]   qam_out,
   output logic                    sample_valid
);

   localparam int c_lut_n  = 2 ** (PHASE_W - 2);
   localparam int c_addr_w = PHASE_W - 2;
   localparam int c_mag_w  = AMP_W - 1;
   localparam int c_sym_w  = (CARR_PER_SYM > 1) ? $clog2(CARR_PER_SYM) : 1;

   localparam logic [c_sym_w-1:0] c_sym_last   = c_sym_w'(CARR_PER_SYM - 1);
   localparam logic [PHASE_W-1:0] c_phase_last = '1;
   localparam logic [PHASE_W-1:0] c_dc_phase   = PHASE_W'((2 ** PHASE_W) - 1 - DC_LEAD);
   localparam logic [PHASE_W-1:0] c_cos_off    = PHASE_W'(c_lut_n);

   // Elaboration-time round(peak*sin(pi/2*(k+0.5)/Q)) in Q2.28 fixed point (Taylor series).
   function automatic logic [c_mag_w-1:0] lut_mag(input int k);
      longint x;
      longint x2;
      longint term;
      longint acc;
      longint res;
      x    = (64'sd843314857 * longint'(2 * k + 1)) / longint'(4 * c_lut_n);
      x2   = (x * x) >>> 28;
      term = x;
      acc  = x;
      for (int n = 1; n <= 12; n++) begin
         term = -((term * x2) >>> 28) / longint'((2 * n) * (2 * n + 1));
         acc  = acc + term;
      end
      res = ((longint'((2 ** c_mag_w) - 1) * acc) + (64'sd1 <<< 27)) >>> 28;
      return c_mag_w'(res);
   endfunction

   logic [c_mag_w-1:0] w_lut [c_lut_n];

   for (genvar gk = 0; gk < c_lut_n; gk++) begin : g_lut
      localparam logic [c_mag_w-1:0] c_mag = lut_mag(gk);
      assign w_lut[gk] = c_mag;
   end

   // ---------------- phase / symbol timing ----------------
   logic [PHASE_W-1:0] r_phase;
   logic [c_sym_w-1:0] r_sym_cnt;
   logic [1:0]         r_sign;
   logic               r_data_change;

   logic               w_wrap;
   logic               w_boundary;
   logic [PHASE_W-1:0] w_phase_nxt;
   logic [c_sym_w-1:0] w_sym_nxt;
   logic [1:0]         w_sign_now;
   logic               w_dc_nxt;
   logic [PHASE_W-1:0] w_cos_phase;

   always_comb begin
      w_wrap      = (r_phase == c_phase_last);
      w_boundary  = (r_phase == '0) && (r_sym_cnt == '0);
      w_phase_nxt = r_phase + 1'b1;
      w_sym_nxt   = r_sym_cnt;
      if (w_wrap) begin
         w_sym_nxt = (r_sym_cnt == c_sym_last) ? '0 : r_sym_cnt + 1'b1;
      end
      // The boundary sample must already carry the freshly sampled sign word.
      w_sign_now  = w_boundary ? elojel_sin_cos : r_sign;
      w_dc_nxt    = (w_phase_nxt == c_dc_phase) && (w_sym_nxt == c_sym_last);
      w_cos_phase = r_phase + c_cos_off;
   end

   always_ff @(posedge clock) begin
      if (!reset) begin
         r_phase       <= '0;
         r_sym_cnt     <= '0;
         r_sign        <= 2'b00;
         r_data_change <= 1'b0;
      end else begin
         r_phase       <= w_phase_nxt;
         r_sym_cnt     <= w_sym_nxt;
         r_sign        <= w_sign_now;
         r_data_change <= w_dc_nxt;
      end
   end

   // ---------------- S1: quadrant / address decode ----------------
   logic                r1_valid;
   logic [c_addr_w-1:0] r1_sin_addr;
   logic [c_addr_w-1:0] r1_cos_addr;
   logic                r1_sin_qneg;
   logic                r1_cos_qneg;
   logic [1:0]          r1_sign;

   always_ff @(posedge clock) begin
      if (!reset) begin
         r1_valid    <= 1'b0;
         r1_sin_addr <= '0;
         r1_cos_addr <= '0;
         r1_sin_qneg <= 1'b0;
         r1_cos_qneg <= 1'b0;
         r1_sign     <= 2'b00;
      end else begin
         r1_valid    <= 1'b1;
         r1_sin_addr <= r_phase[PHASE_W-2] ? ~r_phase[c_addr_w-1:0] : r_phase[c_addr_w-1:0];
         r1_cos_addr <= w_cos_phase[PHASE_W-2] ? ~w_cos_phase[c_addr_w-1:0]
                                               : w_cos_phase[c_addr_w-1:0];
         r1_sin_qneg <= r_phase[PHASE_W-1];
         r1_cos_qneg <= w_cos_phase[PHASE_W-1];
         r1_sign     <= w_sign_now;
      end
   end

   // ---------------- S2: LUT read and sign application ----------------
   logic                    r2_valid;
   logic signed [AMP_W-1:0] r2_sin;
   logic signed [AMP_W-1:0] r2_cos;
   logic signed [AMP_W-1:0] w_sin_pos;
   logic signed [AMP_W-1:0] w_cos_pos;
   logic                    w_sin_neg;
   logic                    w_cos_neg;

   always_comb begin
      w_sin_pos = signed'({1'b0, w_lut[r1_sin_addr]});
      w_cos_pos = signed'({1'b0, w_lut[r1_cos_addr]});
      // Quadrant negation and sign-word negation collapse into a single conditional negate.
      w_sin_neg = r1_sin_qneg ^ r1_sign[1];
      w_cos_neg = r1_cos_qneg ^ r1_sign[0];
   end

   always_ff @(posedge clock) begin
      if (!reset || !r1_valid) begin
         r2_valid <= 1'b0;
         r2_sin   <= '0;
         r2_cos   <= '0;
      end else begin
         r2_valid <= 1'b1;
         r2_sin   <= w_sin_neg ? -w_sin_pos : w_sin_pos;
         r2_cos   <= w_cos_neg ? -w_cos_pos : w_cos_pos;
      end
   end

   // ---------------- S3: sum and aligned output registers ----------------
   logic                    r3_valid;
   logic signed [AMP_W-1:0] r3_sin;
   logic signed [AMP_W-1:0] r3_cos;
   logic signed [AMP_W:0]   r3_qam;

   always_ff @(posedge clock) begin
      if (!reset || !r2_valid) begin
         r3_valid <= 1'b0;
         r3_sin   <= '0;
         r3_cos   <= '0;
         r3_qam   <= '0;
      end else begin
         r3_valid <= 1'b1;
         r3_sin   <= r2_sin;
         r3_cos   <= r2_cos;
         r3_qam   <= {r2_sin[AMP_W-1], r2_sin} + {r2_cos[AMP_W-1], r2_cos};
      end
   end

   assign data_change  = r_data_change;
   assign sin_out      = r3_sin;
   assign cos_out      = r3_cos;
   assign qam_out      = r3_qam;
   assign sample_valid = r3_valid;

endmodule
`default_nettype wire

// File: tb/tb_qam4_carrier_mod.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : tb_qam4_carrier_mod                                               |
// | Brief   : Directed self-checking bench for qam4_carrier_mod (6/8/1/4).      |
// | Revision: 1.0 - initial release                                             |
// +----------------------------------------------------------------------------+
module tb_qam4_carrier_mod;

   localparam int PHASE_W      = 6;
   localparam int AMP_W        = 8;
   localparam int CARR_PER_SYM = 1;
   localparam int DC_LEAD      = 4;

   logic                    clock = 1'b0;
   logic                    reset = 1'b0;
   logic [1:0]              elojel_sin_cos = 2'b00;
   logic                    data_change;
   logic signed [AMP_W-1:0] sin_out;
   logic signed [AMP_W-1:0] cos_out;
   logic signed [AMP_W:0]   qam_out;
   logic                    sample_valid;

   int         n_cmp = 0;
   int         n_err = 0;
   int         mag [16];
   int         edge_cnt = 0;
   logic [1:0] cap_sign = 2'b00;
   logic [1:0] out_sign = 2'b00;

   qam4_carrier_mod #(
      .PHASE_W      (PHASE_W),
      .AMP_W        (AMP_W),
      .CARR_PER_SYM (CARR_PER_SYM),
      .DC_LEAD      (DC_LEAD)
   ) dut (
      .clock          (clock),
      .reset          (reset),
      .elojel_sin_cos (elojel_sin_cos),
      .data_change    (data_change),
      .sin_out        (sin_out),
      .cos_out        (cos_out),
      .qam_out        (qam_out),
      .sample_valid   (sample_valid)
   );

   always #5 clock = ~clock;

   function automatic int gold_sin(input int p);
      int q;
      int low;
      int m;
      q   = (p >> 4) & 3;
      low = p & 15;
      m   = q[0] ? mag[15 - low] : mag[low];
      return q[1] ? -m : m;
   endfunction

   function automatic int exp_sin(input int p, input logic [1:0] s);
      return s[1] ? -gold_sin(p) : gold_sin(p);
   endfunction

   function automatic int exp_cos(input int p, input logic [1:0] s);
      return s[0] ? -gold_sin((p + 16) % 64) : gold_sin((p + 16) % 64);
   endfunction

   // One clock after release; tracks which sign word each output sample should carry.
   task automatic step();
      if (edge_cnt % 64 == 0) cap_sign = elojel_sin_cos;
      @(posedge clock);
      #1;
      edge_cnt++;
      if (edge_cnt >= 3 && (edge_cnt - 3) % 64 == 0) out_sign = cap_sign;
   endtask

   task automatic test_reset();
      reset          = 1'b0;
      elojel_sin_cos = 2'b00;
      for (int i = 0; i < 10; i++) begin
         @(posedge clock);
         #1;
         n_cmp++;
         if ({data_change, sample_valid, sin_out, cos_out, qam_out} !== '0) begin
            n_err++;
            $display("FAIL reset_outputs cyc %0d: got dc=%b v=%b sin=%0d cos=%0d qam=%0d, want all 0",
                     i, data_change, sample_valid, sin_out, cos_out, qam_out);
         end
      end
      reset    = 1'b1;
      edge_cnt = 0;
      for (int i = 1; i <= 2; i++) begin
         step();
         n_cmp++;
         if ({sample_valid, sin_out, cos_out, qam_out} !== '0) begin
            n_err++;
            $display("FAIL pre_valid edge %0d: got v=%b sin=%0d cos=%0d qam=%0d, want all 0",
                     i, sample_valid, sin_out, cos_out, qam_out);
         end
      end
      step();
      n_cmp++;
      if (sample_valid !== 1'b1 || int'(sin_out) !== 6 || int'(cos_out) !== 127 ||
          int'(qam_out) !== 133) begin
         n_err++;
         $display("FAIL first_sample: got v=%b sin=%0d cos=%0d qam=%0d, want v=1 sin=6 cos=127 qam=133",
                  sample_valid, sin_out, cos_out, qam_out);
      end
   endtask

   task automatic test_sign00();
      int smax = -1000;
      int smin = 1000;
      int p;
      for (int i = 0; i < 64; i++) begin
         step();
         p = (edge_cnt - 3) % 64;
         if (int'(sin_out) > smax) smax = int'(sin_out);
         if (int'(sin_out) < smin) smin = int'(sin_out);
         n_cmp++;
         if (sample_valid !== 1'b1 || int'(sin_out) !== exp_sin(p, 2'b00) ||
             int'(cos_out) !== exp_cos(p, 2'b00) ||
             int'(qam_out) !== exp_sin(p, 2'b00) + exp_cos(p, 2'b00)) begin
            n_err++;
            $display("FAIL sign00 ph %0d: got v=%b sin=%0d cos=%0d qam=%0d, want sin=%0d cos=%0d qam=%0d",
                     p, sample_valid, sin_out, cos_out, qam_out, exp_sin(p, 2'b00),
                     exp_cos(p, 2'b00), exp_sin(p, 2'b00) + exp_cos(p, 2'b00));
         end
      end
      n_cmp++;
      if (smax !== 127 || smin !== -127) begin
         n_err++;
         $display("FAIL sin_peaks: got max=%0d min=%0d, want 127/-127", smax, smin);
      end
   endtask

   task automatic test_data_change();
      int pulses = 0;
      int last   = -1;
      for (int i = 0; i < 320; i++) begin
         step();
         if (data_change === 1'b1) begin
            pulses++;
            n_cmp++;
            if (edge_cnt % 64 != 59) begin
               n_err++;
               $display("FAIL dc_phase: pulse at phase %0d, want 59", edge_cnt % 64);
            end
            if (last >= 0) begin
               n_cmp++;
               if (edge_cnt - last != 64) begin
                  n_err++;
                  $display("FAIL dc_spacing: got %0d clocks, want 64", edge_cnt - last);
               end
            end
            last = edge_cnt;
         end
      end
      n_cmp++;
      if (pulses != 5) begin
         n_err++;
         $display("FAIL dc_count: got %0d pulses, want 5", pulses);
      end
   endtask

   task automatic test_sign_change();
      int  p;
      bit  seen = 1'b0;
      for (int i = 0; i < 64 && edge_cnt % 64 != 20; i++) step();
      elojel_sin_cos = 2'b11;
      for (int i = 0; i < 70; i++) begin
         step();
         p = (edge_cnt - 3) % 64;
         n_cmp++;
         if (int'(sin_out) !== exp_sin(p, out_sign) || int'(cos_out) !== exp_cos(p, out_sign) ||
             int'(qam_out) !== exp_sin(p, out_sign) + exp_cos(p, out_sign)) begin
            n_err++;
            $display("FAIL sign11 ph %0d s=%b: got sin=%0d cos=%0d qam=%0d, want %0d %0d %0d",
                     p, out_sign, sin_out, cos_out, qam_out, exp_sin(p, out_sign),
                     exp_cos(p, out_sign), exp_sin(p, out_sign) + exp_cos(p, out_sign));
         end
         if (p == 0 && out_sign == 2'b11 && !seen) begin
            seen = 1'b1;
            n_cmp++;
            if (int'(sin_out) !== -6 || int'(cos_out) !== -127 || int'(qam_out) !== -133) begin
               n_err++;
               $display("FAIL sign11_ph0: got sin=%0d cos=%0d qam=%0d, want -6 -127 -133",
                        sin_out, cos_out, qam_out);
            end
         end
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL sign11_boundary: got no negated phase-0 sample, want one");
      end
   endtask

   task automatic test_sign10();
      int p;
      bit seen = 1'b0;
      elojel_sin_cos = 2'b10;
      for (int i = 0; i < 110; i++) begin
         step();
         p = (edge_cnt - 3) % 64;
         n_cmp++;
         if (int'(sin_out) !== exp_sin(p, out_sign) || int'(cos_out) !== exp_cos(p, out_sign) ||
             int'(qam_out) !== exp_sin(p, out_sign) + exp_cos(p, out_sign)) begin
            n_err++;
            $display("FAIL sign10 ph %0d s=%b: got sin=%0d cos=%0d qam=%0d, want %0d %0d %0d",
                     p, out_sign, sin_out, cos_out, qam_out, exp_sin(p, out_sign),
                     exp_cos(p, out_sign), exp_sin(p, out_sign) + exp_cos(p, out_sign));
         end
         if (p == 0 && out_sign == 2'b10 && !seen) begin
            seen = 1'b1;
            n_cmp++;
            if (int'(sin_out) !== -6 || int'(cos_out) !== 127 || int'(qam_out) !== 121) begin
               n_err++;
               $display("FAIL sign10_ph0: got sin=%0d cos=%0d qam=%0d, want -6 127 121",
                        sin_out, cos_out, qam_out);
            end
         end
      end
      n_cmp++;
      if (!seen) begin
         n_err++;
         $display("FAIL sign10_boundary: got no sign-10 phase-0 sample, want one");
      end
   endtask

   task automatic test_reset_mid();
      int p;
      for (int i = 0; i < 64 && edge_cnt % 64 != 30; i++) step();
      reset          = 1'b0;
      elojel_sin_cos = 2'b01;
      for (int i = 0; i < 2; i++) begin
         @(posedge clock);
         #1;
         n_cmp++;
         if ({data_change, sample_valid, sin_out, cos_out, qam_out} !== '0) begin
            n_err++;
            $display("FAIL midreset cyc %0d: got dc=%b v=%b sin=%0d cos=%0d qam=%0d, want all 0",
                     i, data_change, sample_valid, sin_out, cos_out, qam_out);
         end
      end
      reset    = 1'b1;
      edge_cnt = 0;
      for (int i = 1; i <= 2; i++) begin
         step();
         n_cmp++;
         if (sample_valid !== 1'b0) begin
            n_err++;
            $display("FAIL midreset_valid edge %0d: got v=%b, want 0", i, sample_valid);
         end
      end
      step();
      n_cmp++;
      if (sample_valid !== 1'b1 || int'(sin_out) !== 6 || int'(cos_out) !== -127 ||
          int'(qam_out) !== -121) begin
         n_err++;
         $display("FAIL midreset_restart: got v=%b sin=%0d cos=%0d qam=%0d, want v=1 6 -127 -121",
                  sample_valid, sin_out, cos_out, qam_out);
      end
      for (int i = 0; i < 20; i++) begin
         step();
         p = (edge_cnt - 3) % 64;
         n_cmp++;
         if (int'(sin_out) !== exp_sin(p, 2'b01) || int'(cos_out) !== exp_cos(p, 2'b01)) begin
            n_err++;
            $display("FAIL midreset_run ph %0d: got sin=%0d cos=%0d, want %0d %0d",
                     p, sin_out, cos_out, exp_sin(p, 2'b01), exp_cos(p, 2'b01));
         end
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      for (int k = 0; k < 16; k++) begin
         mag[k] = $rtoi(127.0 * $sin(3.14159265358979 * (real'(k) + 0.5) / 32.0) + 0.5);
      end
      test_reset();
      test_sign00();
      test_data_change();
      test_sign_change();
      test_sign10();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
`default_nettype wire
